// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the adder back end: field widths, FSM encoding,
// packed result layout and the field-packing helper reused by the unpack stage.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int M_W     = FRAC_W + 2;
  localparam int EXP_MAX = 31;
  localparam int BIAS    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  function automatic fp16_t pack_fp16(input logic              sign,
                                      input logic [EXP_W-1:0]  expo,
                                      input logic [FRAC_W-1:0] frac);
    fp16_t r;
    r.sign = sign;
    r.expo = expo;
    r.frac = frac;
    return r;
  endfunction

endpackage

// File: rtl/fp16_normalize_pack.sv
// Normalizes the adder's 12-bit mantissa sum one shift per cycle and packs binary16 with ovf/unf flags.
// Latency k+2 cycles for k left shifts (max 12); one operation in flight, in_ready73 only in IDLE.
// Result held until out_ready73; FP_NORM_ROUND_EN selects round-to-nearest-even on the carry shift.
module fp16_normalize_pack
  import fp16_pkg::*;
(
  input  logic        clk73,
  input  logic        rst73,
  input  logic        in_valid73,
  output logic        in_ready73,
  input  logic        res_sign73,
  input  logic [11:0] m_sum73,
  input  logic [4:0]  exp_in73,
  output logic        out_valid73,
  input  logic        out_ready73,
  output logic [15:0] result73,
  output logic        overflow73,
  output logic        underflow73
);

  state_t            state, state_nxt;
  logic              sign_q, sign_nxt;
  logic [M_W-1:0]    m_q, m_nxt;
  logic [5:0]        e_q, e_nxt;
  fp16_t             res_q, res_nxt;
  logic              ovf_q, ovf_nxt;
  logic              unf_q, unf_nxt;

  // Carry right-shift candidate: fraction and exponent after the shift (and optional rounding).
  logic [FRAC_W-1:0] frac_c;
  logic [5:0]        e_c;
`ifdef FP_NORM_ROUND_EN
  logic [M_W-1:0]    m_inc;
`endif

  always_comb begin
    frac_c = m_q[FRAC_W:1];
    e_c    = e_q + 6'd1;
`ifdef FP_NORM_ROUND_EN
    // Ties can only round up when the retained LSB is odd, so dropped&lsb is the full RNE rule.
    m_inc = {1'b0, m_q[M_W-1:1]} + {{(M_W-1){1'b0}}, m_q[1] & m_q[0]};
    if (m_inc[M_W-1]) begin
      frac_c = m_inc[FRAC_W:1];
      e_c    = e_q + 6'd2;
    end else begin
      frac_c = m_inc[FRAC_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk73) begin
    if (rst73) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      m_q    <= '0;
      e_q    <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sign_q <= sign_nxt;
      m_q    <= m_nxt;
      e_q    <= e_nxt;
      res_q  <= res_nxt;
      ovf_q  <= ovf_nxt;
      unf_q  <= unf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sign_nxt  = sign_q;
    m_nxt     = m_q;
    e_nxt     = e_q;
    res_nxt   = res_q;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;

    case (state)
      IDLE: begin
        if (in_valid73) begin
          sign_nxt  = res_sign73;
          m_nxt     = m_sum73;
          // A zero exponent field behaves as exponent 1 (subnormal scale).
          e_nxt     = (exp_in73 == '0) ? 6'd1 : {1'b0, exp_in73};
          res_nxt   = '0;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
          state_nxt = NORM;
        end
      end

      NORM: begin
        state_nxt = DONE;
        if (m_q == '0) begin
          res_nxt = pack_fp16(1'b0, '0, '0);
        end else if (e_q == 6'(EXP_MAX)) begin
          res_nxt = pack_fp16(sign_q, EXP_W'(EXP_MAX), '0);
          ovf_nxt = 1'b1;
        end else if (m_q[M_W-1]) begin
          if (e_c >= 6'(EXP_MAX)) begin
            res_nxt = pack_fp16(sign_q, EXP_W'(EXP_MAX), '0);
            ovf_nxt = 1'b1;
          end else begin
            res_nxt = pack_fp16(sign_q, e_c[EXP_W-1:0], frac_c);
          end
        end else if (m_q[FRAC_W]) begin
          res_nxt = pack_fp16(sign_q, e_q[EXP_W-1:0], m_q[FRAC_W-1:0]);
        end else if (e_q <= 6'd1) begin
          res_nxt = pack_fp16(sign_q, '0, m_q[FRAC_W-1:0]);
          unf_nxt = 1'b1;
        end else begin
          m_nxt     = {m_q[M_W-2:0], 1'b0};
          e_nxt     = e_q - 6'd1;
          state_nxt = NORM;
        end
      end

      DONE: begin
        if (out_ready73) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready73  = (state == IDLE);
  assign out_valid73 = (state == DONE);
  assign result73    = res_q;
  assign overflow73  = ovf_q;
  assign underflow73 = unf_q;

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Directed bench for fp16_normalize_pack: hand-computed vectors, latency, backpressure and reset abort.
module tb_fp16_normalize_pack;

  logic        clk73 = 1'b0;
  logic        rst73;
  logic        in_valid73;
  logic        in_ready73;
  logic        res_sign73;
  logic [11:0] m_sum73;
  logic [4:0]  exp_in73;
  logic        out_valid73;
  logic        out_ready73;
  logic [15:0] result73;
  logic        overflow73;
  logic        underflow73;

  int total = 0;
  int bad   = 0;

  fp16_normalize_pack dut (
    .clk73       (clk73),
    .rst73       (rst73),
    .in_valid73  (in_valid73),
    .in_ready73  (in_ready73),
    .res_sign73  (res_sign73),
    .m_sum73     (m_sum73),
    .exp_in73    (exp_in73),
    .out_valid73 (out_valid73),
    .out_ready73 (out_ready73),
    .result73    (result73),
    .overflow73  (overflow73),
    .underflow73 (underflow73)
  );

  always #5 clk73 = ~clk73;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk73);
    #1;
  endtask

  // Presents one operand; returns one cycle after the accepting edge (cycle 1).
  task automatic start(input logic s, input logic [11:0] m, input logic [4:0] e);
    int guard = 0;
    while (!in_ready73 && guard < 40) begin
      tick();
      guard++;
    end
    res_sign73 = s;
    m_sum73    = m;
    exp_in73   = e;
    in_valid73 = 1'b1;
    tick();
    in_valid73 = 1'b0;
  endtask

  // Waits for out_valid73 and returns the cycle number it was first seen in.
  task automatic wait_done(output int cyc, output logic rdy_seen);
    cyc      = 1;
    rdy_seen = 1'b0;
    while (!out_valid73 && cyc < 40) begin
      rdy_seen |= in_ready73;
      tick();
      cyc++;
    end
    rdy_seen |= in_ready73;
  endtask

  task automatic drain(input string tag);
    out_ready73 = 1'b1;
    tick();
    out_ready73 = 1'b0;
    chk({tag, ".idle_rdy"}, {31'd0, in_ready73}, 32'd1);
  endtask

  task automatic run(input string tag, input logic s, input logic [11:0] m, input logic [4:0] e,
                     input logic [15:0] exp_res, input logic exp_ovf, input logic exp_unf,
                     input int exp_lat);
    int   cyc;
    logic rdy_seen;
    start(s, m, e);
    wait_done(cyc, rdy_seen);
    chk({tag, ".lat"}, cyc, exp_lat);
    chk({tag, ".res"}, {16'd0, result73}, {16'd0, exp_res});
    chk({tag, ".ovf"}, {31'd0, overflow73}, {31'd0, exp_ovf});
    chk({tag, ".unf"}, {31'd0, underflow73}, {31'd0, exp_unf});
    chk({tag, ".busy"}, {31'd0, rdy_seen}, 32'd0);
    drain(tag);
  endtask

  initial begin
    int   cyc;
    logic rdy_seen;
    logic [15:0] held;

    rst73       = 1'b1;
    in_valid73  = 1'b0;
    out_ready73 = 1'b0;
    res_sign73  = 1'b0;
    m_sum73     = '0;
    exp_in73    = '0;
    tick();
    tick();
    rst73 = 1'b0;
    chk("rst.rdy", {31'd0, in_ready73}, 32'd1);
    chk("rst.vld", {31'd0, out_valid73}, 32'd0);
    chk("rst.res", {16'd0, result73}, 32'd0);
    chk("rst.flags", {30'd0, overflow73, underflow73}, 32'd0);

    run("t1",      1'b0, 12'h600, 5'd15, 16'h3E00, 1'b0, 1'b0, 2);
    run("t2carry", 1'b0, 12'h800, 5'd15, 16'h4000, 1'b0, 1'b0, 2);
    run("t2ovf",   1'b0, 12'hFFE, 5'd30, 16'h7C00, 1'b1, 1'b0, 2);
    run("t3",      1'b1, 12'h001, 5'd15, 16'h9400, 1'b0, 1'b0, 12);
    run("t4zero",  1'b1, 12'h000, 5'd20, 16'h0000, 1'b0, 1'b0, 2);
    run("t4unf",   1'b0, 12'h010, 5'd3,  16'h0040, 1'b0, 1'b1, 4);
    run("exp31",   1'b1, 12'h400, 5'd31, 16'hFC00, 1'b1, 1'b0, 2);
    run("exp0nrm", 1'b0, 12'h400, 5'd0,  16'h0400, 1'b0, 1'b0, 2);
    run("exp0sub", 1'b0, 12'h200, 5'd0,  16'h0200, 1'b0, 1'b1, 2);
    run("tie_even", 1'b0, 12'h805, 5'd15, 16'h4002, 1'b0, 1'b0, 2);
`ifdef FP_NORM_ROUND_EN
    run("rnd803",  1'b0, 12'h803, 5'd15, 16'h4002, 1'b0, 1'b0, 2);
    run("rndFFF",  1'b0, 12'hFFF, 5'd15, 16'h4400, 1'b0, 1'b0, 2);
`else
    run("rnd803",  1'b0, 12'h803, 5'd15, 16'h4001, 1'b0, 1'b0, 2);
    run("rndFFF",  1'b0, 12'hFFF, 5'd15, 16'h43FF, 1'b0, 1'b0, 2);
`endif

    // Backpressure: result and flags frozen, no new accept while a competing input is offered.
    start(1'b0, 12'hFFE, 5'd30);
    wait_done(cyc, rdy_seen);
    chk("t5.lat", cyc, 2);
    held = result73;
    chk("t5.first", {16'd0, held}, 32'h7C00);
    res_sign73 = 1'b1;
    m_sum73    = 12'h600;
    exp_in73   = 5'd10;
    in_valid73 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5.vld", {31'd0, out_valid73}, 32'd1);
      chk("t5.res", {16'd0, result73}, {16'd0, held});
      chk("t5.ovf", {31'd0, overflow73}, 32'd1);
      chk("t5.rdy", {31'd0, in_ready73}, 32'd0);
    end
    in_valid73 = 1'b0;
    drain("t5");
    chk("t5.vld_off", {31'd0, out_valid73}, 32'd0);

    // Reset while mid-shift abandons the operation.
    start(1'b1, 12'h001, 5'd15);
    tick();
    tick();
    tick();
    rst73 = 1'b1;
    tick();
    rst73 = 1'b0;
    chk("t6.vld", {31'd0, out_valid73}, 32'd0);
    chk("t6.res", {16'd0, result73}, 32'd0);
    chk("t6.rdy", {31'd0, in_ready73}, 32'd1);
    chk("t6.flags", {30'd0, overflow73, underflow73}, 32'd0);
    run("t6.redo", 1'b0, 12'h600, 5'd15, 16'h3E00, 1'b0, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
